// File: rtl/test_sequencer_pkg.sv
// rtl/test_sequencer_pkg.sv - shared state encoding and phase defaults for the run sequencer
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

    localparam int DEFAULT_RESET_CYCLES = 4;
    localparam int DEFAULT_DRAIN_CYCLES = 8;

    function automatic logic is_busy_state(input seq_state_e s);
        return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/test_sequencer_phase_timer.sv
// rtl/test_sequencer_phase_timer.sv - loadable down-counter timing the CLEAR and DRAIN phases
module seq_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/test_sequencer.sv
// rtl/test_sequencer.sv - hardware run sequence: clear, enable N vectors, drain, snapshot, done
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_num_vectors,
    input  logic [WIDTH-1:0] i_data_ctr,
    input  logic [WIDTH-1:0] i_event_ctr,
    output logic             o_hpc_reset,
    output logic             o_hpc_enable,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [WIDTH-1:0] o_vec_ctr,
    output logic [WIDTH-1:0] o_data_snap,
    output logic [WIDTH-1:0] o_event_snap,
    output logic [2:0]       o_state
);

    localparam int PHASE_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int TW        = $clog2(PHASE_MAX + 1);

    seq_state_e       state_q, next_state;
    logic [WIDTH-1:0] num_q;
    logic             hpc_reset_q;
    logic             start_taken, abort_taken;
    logic             timer_load, timer_dec, timer_zero;
    logic [TW-1:0]    timer_value;

    seq_phase_timer #(.WIDTH(TW)) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    assign timer_dec = (state_q == ST_CLEAR) || (state_q == ST_DRAIN);

    always_comb begin
        next_state  = state_q;
        start_taken = 1'b0;
        abort_taken = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start && !i_abort) begin
                    next_state  = ST_CLEAR;
                    start_taken = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TW'(RESET_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    next_state  = ST_IDLE;
                    abort_taken = 1'b1;
                end else if (timer_zero) begin
                    if (num_q == '0) begin
                        next_state  = ST_DRAIN;
                        timer_load  = 1'b1;
                        timer_value = TW'(DRAIN_CYCLES - 1);
                    end else begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    next_state  = ST_IDLE;
                    abort_taken = 1'b1;
                end else if (o_vec_ctr == num_q - WIDTH'(1)) begin
                    next_state  = ST_DRAIN;
                    timer_load  = 1'b1;
                    timer_value = TW'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (i_abort) begin
                    next_state  = ST_IDLE;
                    abort_taken = 1'b1;
                end else if (timer_zero) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_abort) begin
                    next_state  = ST_IDLE;
                    abort_taken = 1'b1;
                end else begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output flops are driven from next_state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_q        <= '0;
            hpc_reset_q  <= 1'b0;
            o_hpc_enable <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_vec_ctr    <= '0;
            o_data_snap  <= '0;
            o_event_snap <= '0;
        end else begin
            state_q      <= next_state;
            hpc_reset_q  <= (next_state == ST_CLEAR);
            o_hpc_enable <= (next_state == ST_RUN);
            o_busy       <= is_busy_state(next_state);
            o_done       <= (next_state == ST_DONE);
            o_aborted    <= abort_taken;
            if (start_taken) begin
                num_q     <= i_num_vectors;
                o_vec_ctr <= '0;
            end else if ((state_q == ST_RUN) && !abort_taken) begin
                o_vec_ctr <= o_vec_ctr + WIDTH'(1);
            end
            if ((state_q == ST_CAPTURE) && !abort_taken) begin
                o_data_snap  <= i_data_ctr;
                o_event_snap <= i_event_ctr;
            end
        end
    end

    // Downstream reset follows the async reset immediately in both directions.
    assign o_hpc_reset = hpc_reset_q | reset;
    assign o_state     = state_q;

endmodule

// File: tb/tb_test_sequencer.sv
// tb/tb_test_sequencer.sv - directed table-driven bench for test_sequencer
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start, i_abort;
    logic [31:0] i_num_vectors, i_data_ctr, i_event_ctr;
    logic        o_hpc_reset, o_hpc_enable, o_busy, o_done, o_aborted;
    logic [31:0] o_vec_ctr, o_data_snap, o_event_snap;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    test_sequencer #(.WIDTH(32), .RESET_CYCLES(4), .DRAIN_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_num_vectors (i_num_vectors),
        .i_data_ctr    (i_data_ctr),
        .i_event_ctr   (i_event_ctr),
        .o_hpc_reset   (o_hpc_reset),
        .o_hpc_enable  (o_hpc_enable),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_aborted     (o_aborted),
        .o_vec_ctr     (o_vec_ctr),
        .o_data_snap   (o_data_snap),
        .o_event_snap  (o_event_snap),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] num;
        logic [31:0] data;
        logic [31:0] evt;
        int          abort_j;
        int          start_j;
        int          exp_rst;
        int          exp_en;
        int          exp_busy;
        int          exp_abt;
        int          exp_done;
        int          exp_first_en;
        logic [31:0] exp_vec;
        logic [31:0] exp_dsnap;
        logic [31:0] exp_esnap;
        logic [2:0]  exp_state;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // j counts sampled cycles after the start edge; done cycle counts the start cycle as 1.
    task automatic run_vec(input vec_t v, input string tag);
        int rst_cnt, en_cnt, busy_cnt, abt_cnt, done_c, first_en;
        rst_cnt = 0; en_cnt = 0; busy_cnt = 0; abt_cnt = 0; done_c = -1; first_en = -1;
        @(negedge clk);
        i_start       = 1'b1;
        i_abort       = 1'b0;
        i_num_vectors = v.num;
        i_data_ctr    = JUNK;
        i_event_ctr   = JUNK;
        @(posedge clk);
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (o_hpc_reset)  rst_cnt++;
            if (o_hpc_enable) en_cnt++;
            if (o_busy)       busy_cnt++;
            if (o_aborted)    abt_cnt++;
            if (o_hpc_enable && first_en < 0) first_en = j;
            if (o_done && done_c < 0) done_c = j + 1;
            i_start       = (j == v.start_j);
            i_num_vectors = 32'd99;
            i_abort       = (j == v.abort_j);
            i_data_ctr    = (j == v.exp_done - 2) ? v.data : JUNK;
            i_event_ctr   = (j == v.exp_done - 2) ? v.evt  : JUNK;
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        chk({tag, " reset_cycles"}, rst_cnt, v.exp_rst);
        chk({tag, " enable_cycles"}, en_cnt, v.exp_en);
        chk({tag, " first_enable"}, first_en, v.exp_first_en);
        chk({tag, " busy_cycles"}, busy_cnt, v.exp_busy);
        chk({tag, " abort_pulses"}, abt_cnt, v.exp_abt);
        chk({tag, " done_cycle"}, done_c, v.exp_done);
        chk({tag, " vec_ctr"}, o_vec_ctr, v.exp_vec);
        chk({tag, " data_snap"}, o_data_snap, v.exp_dsnap);
        chk({tag, " event_snap"}, o_event_snap, v.exp_esnap);
        chk({tag, " state"}, o_state, v.exp_state);
        if (v.exp_done > 0) begin
            i_data_ctr  = 32'h5555;
            i_event_ctr = 32'h6666;
            repeat (2) @(negedge clk);
            chk({tag, " data_snap_held"}, o_data_snap, v.exp_dsnap);
            chk({tag, " event_snap_held"}, o_event_snap, v.exp_esnap);
            chk({tag, " done_held"}, o_done, 1'b1);
        end
    endtask

    initial begin
        //          num    data      evt   abt  st  rst en busy abt done fen vec    dsnap     esnap  state
        tbl[0] = '{32'd10, 32'h1234, 32'h5,  -1, -1, 4, 10, 23, 0, 24,  4, 32'd10, 32'h1234, 32'h5,  3'd5};
        tbl[1] = '{32'd0,  32'hAAAA, 32'h77, -1, -1, 4, 0,  13, 0, 14, -1, 32'd0,  32'hAAAA, 32'h77, 3'd5};
        tbl[2] = '{32'd1,  32'hBEEF, 32'h1,  -1, -1, 4, 1,  14, 0, 15,  4, 32'd1,  32'hBEEF, 32'h1,  3'd5};
        tbl[3] = '{32'd10, 32'h0,    32'h0,   7, -1, 4, 4,  8,  1, -1,  4, 32'd3,  32'hBEEF, 32'h1,  3'd0};
        tbl[4] = '{32'd2,  32'h0,    32'h0,   1, -1, 2, 0,  2,  1, -1, -1, 32'd0,  32'hBEEF, 32'h1,  3'd0};
        tbl[5] = '{32'd5,  32'h42,   32'h9,  -1,  6, 4, 5,  18, 0, 19,  4, 32'd5,  32'h42,   32'h9,  3'd5};

        reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_num_vectors = '0; i_data_ctr = '0; i_event_ctr = '0;
        #1;
        chk("reset hpc_reset", o_hpc_reset, 1'b1);
        chk("reset outputs", {o_hpc_enable, o_busy, o_done, o_aborted, o_state}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release hpc_reset", o_hpc_reset, 1'b0);

        // Start and abort together in IDLE: abort wins, nothing starts.
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1; i_num_vectors = 32'd4;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        chk("start_abort state", o_state, 3'd0);
        chk("start_abort flags", {o_hpc_reset, o_busy, o_aborted}, 3'b000);
        @(negedge clk);
        chk("start_abort no reset", o_hpc_reset, 1'b0);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_vec(tbl[i], tag);
        end

        // Async reset in the middle of DRAIN, then a clean run.
        @(negedge clk);
        i_start = 1'b1; i_num_vectors = 32'd2;
        @(negedge clk);
        i_start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst hpc_reset", o_hpc_reset, 1'b1);
        chk("midrst outputs", {o_hpc_enable, o_busy, o_done, o_aborted, o_state}, '0);
        chk("midrst vec_ctr", o_vec_ctr, 32'd0);
        chk("midrst data_snap", o_data_snap, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst release hpc_reset", o_hpc_reset, 1'b0);
        chk("midrst release state", o_state, 3'd0);
        run_vec('{32'd3, 32'hC0DE, 32'h3, -1, -1, 4, 3, 16, 0, 17, 4, 32'd3, 32'hC0DE, 32'h3, 3'd5}, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Run controller for the arithmetic testbench. It replaces the software-toggled reset and enable bits with a hardware sequence: clear the testbench, enable the randomisers for exactly N vectors, wait for the DUT/monitor pipeline to drain, then snapshot the scoreboard counters and flag completion. It sits between the Avalon register block and the randomiser/driver/monitor/scoreboard chain, in the clk_dut domain.

## Interface
- WIDTH, 32, width of vector count and counter snapshots
- RESET_CYCLES, 4, cycles o_hpc_reset is held high in CLEAR (≥1)
- DRAIN_CYCLES, 8, cycles waited after the last vector before capture (≥1)
- clk  in  1  clock (clk_dut domain)
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle request to begin a run
- i_abort  in  1  single-cycle request to cancel a run
- i_num_vectors  in  WIDTH  vectors per run; sampled on accepted start
- i_data_ctr  in  WIDTH  scoreboard data counter
- i_event_ctr  in  WIDTH  scoreboard event counter
- o_hpc_reset  out  1  reset to randomisers/driver/monitor/scoreboard
- o_hpc_enable  out  1  randomiser enable
- o_busy  out  1  high in CLEAR, RUN, DRAIN, CAPTURE
- o_done  out  1  high in DONE
- o_aborted  out  1  one-cycle pulse when an abort is taken
- o_vec_ctr  out  WIDTH  vectors issued in the current or last run
- o_data_snap  out  WIDTH  i_data_ctr captured at end of run
- o_event_snap  out  WIDTH  i_event_ctr captured at end of run
- o_state  out  3  state encoding, for register readback

## Operation
- States: IDLE=0, CLEAR=1, RUN=2, DRAIN=3, CAPTURE=4, DONE=5.
- IDLE/DONE + i_start (and no i_abort) -> CLEAR. Latch i_num_vectors, clear o_vec_ctr and the phase counter.
- CLEAR: o_hpc_reset=1 for RESET_CYCLES cycles. Then RUN, or DRAIN directly if the latched count is 0.
- RUN: o_hpc_enable=1. o_vec_ctr increments every cycle. When o_vec_ctr reaches count-1 (last vector), the next state is DRAIN.
- DRAIN: enable low for DRAIN_CYCLES cycles, then CAPTURE.
- CAPTURE: one cycle; load o_data_snap and o_event_snap from the inputs; -> DONE.
- DONE: o_done=1. It holds until the next accepted start.
- i_start while busy: ignored.
- i_abort in CLEAR/RUN/DRAIN/CAPTURE: go to IDLE next cycle and pulse o_aborted. Snapshots are not updated. o_vec_ctr keeps the value it has reached.
- i_abort in IDLE/DONE: no effect.
- i_start and i_abort in the same cycle: abort wins and no run starts.
- Count 2^WIDTH-1 is legal. o_vec_ctr never wraps within a run.
- Reset, including mid-run: state=IDLE. All outputs are 0 except o_hpc_reset, which is 1 while reset is asserted and 0 after release.

## Timing
- All outputs are registered. Outputs reflect the current state.
- Start accepted at edge 0. o_hpc_reset is high for cycles 1..RESET_CYCLES. o_hpc_enable is high for exactly N cycles, starting at cycle RESET_CYCLES+1.
- Total run length from start to the first o_done cycle: 1 + RESET_CYCLES + N + DRAIN_CYCLES + 1 cycles; DONE is entered on the following edge.
- Snapshots are valid from the first DONE cycle.
- Abort latency: 1 cycle. o_hpc_enable is low in the cycle after abort is sampled.

## Structure
- Shared package holds:
  - the state enumeration and its 3-bit encoding, reused by register readback decode;
  - default RESET_CYCLES and DRAIN_CYCLES.
- One sub-module: seq_phase_timer. This is a loadable down-counter with a `zero` flag, shared by the CLEAR and DRAIN phases.
- The vector counter stays in the top level.

## Test plan
- RESET_CYCLES=4, DRAIN=8, N=10, start pulse:
  - o_hpc_reset high 4 cycles, then o_hpc_enable high exactly 10 cycles;
  - o_done rises 24 cycles after the start edge;
  - o_vec_ctr=10.
- N=0:
  - enable never rises;
  - DONE is reached after CLEAR + DRAIN + CAPTURE;
  - o_vec_ctr=0.
- Snapshot: drive i_data_ctr=0x1234 and i_event_ctr=0x5 during CAPTURE -> o_data_snap=0x1234 and o_event_snap=0x5. These values are held unchanged through later input changes while in DONE.
- Abort in RUN after 3 vectors of N=10 -> next cycle:
  - IDLE, enable 0;
  - o_aborted pulses for 1 cycle;
  - o_done stays 0, o_vec_ctr=3;
  - snapshots unchanged.
- Start and abort together in IDLE -> stays IDLE with no reset pulse. Start pulses during RUN are ignored and the count is unaffected.
- Assert reset asynchronously mid-DRAIN -> outputs clear immediately with o_hpc_reset high. After release:
  - IDLE, o_hpc_reset 0;
  - a new start runs normally.
